// File: rtl/mux_8x1.sv
// rtl/mux_8x1.sv - registered 8:1 word mux from three 4:1 stages; MUX_8X1_PARITY_EN adds y_parity
module mux_4x1 #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = d0;
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end
endmodule

module mux_8x1 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic [2:0]       sel,
`ifdef MUX_8X1_PARITY_EN
    output logic             y_parity,
`endif
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);
    logic [WIDTH-1:0] leaf_a;
    logic [WIDTH-1:0] leaf_b;
    logic [WIDTH-1:0] root_y;

    mux_4x1 #(.WIDTH(WIDTH)) u_leaf_a (
        .d0(i0), .d1(i1), .d2(i2), .d3(i3), .s(sel[1:0]), .y(leaf_a)
    );

    mux_4x1 #(.WIDTH(WIDTH)) u_leaf_b (
        .d0(i4), .d1(i5), .d2(i6), .d3(i7), .s(sel[1:0]), .y(leaf_b)
    );

    // Root only ever uses its lower half; upper inputs mirror it so the stage stays a plain 4:1.
    mux_4x1 #(.WIDTH(WIDTH)) u_root (
        .d0(leaf_a), .d1(leaf_b), .d2(leaf_a), .d3(leaf_b), .s({1'b0, sel[2]}), .y(root_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= root_y;
            end
        end
    end

`ifdef MUX_8X1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            y_parity <= 1'b0;
        end else if (in_valid) begin
            y_parity <= ^root_y;
        end
    end
`endif
endmodule

// File: tb/tb_mux_8x1.sv
// tb/tb_mux_8x1.sv - randomized self-checking bench for mux_8x1 against an array-lookup model
module tb_mux_8x1;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] data [8];
    logic [2:0]   sel;
    logic [W-1:0] y;
    logic         out_valid;
`ifdef MUX_8X1_PARITY_EN
    logic         y_parity;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_y = '0;
    logic         exp_v = 1'b0;

    always #5 clk = ~clk;

    mux_8x1 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .i0(data[0]), .i1(data[1]), .i2(data[2]), .i3(data[3]),
        .i4(data[4]), .i5(data[5]), .i6(data[6]), .i7(data[7]),
        .sel(sel),
`ifdef MUX_8X1_PARITY_EN
        .y_parity(y_parity),
`endif
        .y(y), .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_ones(input logic [W-1:0] v);
        int n = 0;
        for (int b = 0; b < W; b++) if (v[b]) n++;
        return (n % 2) == 1;
    endfunction

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic v, input logic [2:0] s);
        rst      = r;
        in_valid = v;
        sel      = s;
        if (r) begin
            exp_y = '0;
            exp_v = 1'b0;
        end else if (v) begin
            exp_y = data[s];
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_y"}, 32'(y), 32'(exp_y));
        check({tag, "_v"}, 32'(out_valid), 32'(exp_v));
`ifdef MUX_8X1_PARITY_EN
        check({tag, "_par"}, 32'(y_parity), 32'(odd_ones(exp_y)));
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        sel = '0;
        for (int k = 0; k < 8; k++) data[k] = W'(k);
        #1;

        cycle("reset0", 1'b1, 1'b1, 3'd5);
        cycle("reset1", 1'b1, 1'b1, 3'd6);

        for (int k = 0; k < 8; k++) cycle("sweep", 1'b0, 1'b1, 3'(k));

        for (int k = 0; k < 8; k++) data[k] = W'(7 - k);
        cycle("rev2", 1'b0, 1'b1, 3'd2);
        check("rev2_lit", 32'(y), 32'd5);
        cycle("rev5", 1'b0, 1'b1, 3'd5);
        check("rev5_lit", 32'(y), 32'd2);

        for (int k = 0; k < 8; k++) data[k] = W'(k);
        cycle("hold_load", 1'b0, 1'b1, 3'd6);
        for (int n = 0; n < 3; n++) cycle("hold", 1'b0, 1'b0, 3'd1);
        check("hold_lit", 32'(y), 32'd6);
        cycle("hold_x", 1'b0, 1'b0, 3'bxxx);

        cycle("rst_prio", 1'b1, 1'b1, 3'd7);
        cycle("after_rst", 1'b0, 1'b1, 3'd3);
        check("after_rst_lit", 32'(y), 32'd3);

        cycle("par7", 1'b0, 1'b1, 3'd7);
        cycle("par3", 1'b0, 1'b1, 3'd3);

        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 8; k++) data[k] = W'($urandom);
            cycle("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
